// File: rtl/ext_bus_uart_tx.sv
// External-bus register responder with a TX FIFO feeding an 8N1 UART serializer.
// Bus transfers complete with a one-cycle acknowledge; write side effects commit with that acknowledge.
module ext_bus_uart_tx #(
    parameter int FIFO_DEPTH       = 16,
    parameter int DEFAULT_BAUD_DIV = 433
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [2:0]  bus_address,
    input  logic        bus_enable,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_rw,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    output logic        bus_acknowledge,
    output logic        bus_irq,
    output logic        uart_txd
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;

    logic              ack_reg;
    logic [31:0]       rdata_reg;
    logic              irq_reg;
    logic              irq_en_reg;
    logic              tx_en_reg;
    logic              ovf_reg;
    logic [15:0]       baud_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [7:0]        mem [FIFO_DEPTH];

    tx_state_t         state_reg, state_next;
    logic [15:0]       cnt_reg, cnt_next;
    logic [15:0]       div_reg, div_next;
    logic [2:0]        bit_reg, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic              txd_reg, txd_next;
    logic              pop;

    logic              access, wr_access, rd_access;
    logic              push_req, push, ovf_set;
    logic              full, empty, busy;
    logic [31:0]       rd_mux;
    logic [15:0]       baud_merge;
    logic [15:0]       baud_new;
    logic              unused_bits;

    // A request seen while the acknowledge is high is the tail of the same transfer.
    assign access    = bus_enable & ~ack_reg;
    assign wr_access = access & ~bus_rw;
    assign rd_access = access & bus_rw;

    assign full  = (level_reg == LVL_W'(FIFO_DEPTH));
    assign empty = (level_reg == '0);
    assign busy  = (state_reg != ST_IDLE);

    // When full, a same-cycle pop frees the slot before the push lands.
    assign push_req = wr_access & (bus_address == 3'd0) & bus_byte_enable[0];
    assign push     = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_baud_lane
            assign baud_merge[gi*8 +: 8] = bus_byte_enable[gi] ? bus_write_data[gi*8 +: 8]
                                                                : baud_reg[gi*8 +: 8];
        end
    endgenerate
    assign baud_new = (baud_merge == 16'd0) ? 16'd1 : baud_merge;

    assign unused_bits = ^{bus_write_data[31:16], bus_byte_enable[3:2]};

    always_comb begin
        rd_mux = 32'd0;
        case (bus_address)
            3'd1:    rd_mux = {16'd0, 8'(level_reg), 4'd0, ovf_reg, busy, empty, full};
            3'd2:    rd_mux = {30'd0, tx_en_reg, irq_en_reg};
            3'd3:    rd_mux = {16'd0, baud_reg};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ack_reg    <= 1'b0;
            rdata_reg  <= 32'd0;
            irq_reg    <= 1'b0;
            irq_en_reg <= 1'b0;
            tx_en_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            baud_reg   <= 16'(DEFAULT_BAUD_DIV);
        end else begin
            ack_reg   <= access;
            rdata_reg <= rd_access ? rd_mux : 32'd0;
            irq_reg   <= irq_en_reg & empty & ~busy;
            if (wr_access && bus_address == 3'd2 && bus_byte_enable[0]) begin
                irq_en_reg <= bus_write_data[0];
                tx_en_reg  <= bus_write_data[1];
            end
            if (wr_access && bus_address == 3'd3 && (bus_byte_enable[1:0] != 2'b00)) begin
                baud_reg <= baud_new;
            end
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (wr_access && bus_address == 3'd1 && bus_byte_enable[0] && bus_write_data[3]) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr_reg] <= bus_write_data[7:0];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (tx_en_reg && !empty) begin
                    pop        = 1'b1;
                    div_next   = baud_reg;
                    cnt_next   = 16'd0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt_reg == div_reg) begin
                    cnt_next   = 16'd0;
                    bit_next   = 3'd0;
                    state_next = ST_DATA;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_reg == div_reg) begin
                    cnt_next   = 16'd0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) state_next = ST_STOP;
                    else                 bit_next   = bit_reg + 3'd1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_reg == div_reg) begin
                    cnt_next = 16'd0;
                    // Chain straight into the next start bit when more data is waiting.
                    if (tx_en_reg && !empty) begin
                        pop        = 1'b1;
                        div_next   = baud_reg;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        txd_next = 1'b1;
        if (state_next == ST_START)     txd_next = 1'b0;
        else if (state_next == ST_DATA) txd_next = shift_next[0];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 16'd0;
            div_reg   <= 16'd0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
            txd_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            shift_reg <= pop ? mem[rd_ptr_reg] : shift_next;
            txd_reg   <= txd_next;
        end
    end

    assign bus_acknowledge = ack_reg;
    assign bus_read_data   = rdata_reg;
    assign bus_irq         = irq_reg;
    assign uart_txd        = txd_reg;
endmodule

// File: tb/tb_ext_bus_uart_tx.sv
// Bench for ext_bus_uart_tx: register accesses checked against constants, UART frames against a byte scoreboard.
module tb_ext_bus_uart_tx;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [2:0]  bus_address = 3'd0;
    logic        bus_enable = 1'b0;
    logic [3:0]  bus_byte_enable = 4'd0;
    logic        bus_rw = 1'b0;
    logic [31:0] bus_write_data = 32'd0;
    logic [31:0] bus_read_data;
    logic        bus_acknowledge;
    logic        bus_irq;
    logic        uart_txd;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int cur_div = 433;
    bit mon_en = 1'b1;
    int frames_seen = 0;
    int last_end_cyc = 0;
    int b2b_gap = 0;
    bit irq_busy_seen = 1'b0;
    logic [7:0] byte_q[$];

    ext_bus_uart_tx #(.FIFO_DEPTH(16), .DEFAULT_BAUD_DIV(433)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus_address(bus_address),
        .bus_enable(bus_enable),
        .bus_byte_enable(bus_byte_enable),
        .bus_rw(bus_rw),
        .bus_write_data(bus_write_data),
        .bus_read_data(bus_read_data),
        .bus_acknowledge(bus_acknowledge),
        .bus_irq(bus_irq),
        .uart_txd(uart_txd)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] frame_bits(input logic [7:0] b, input int div);
        logic [63:0] f;
        int sym;
        f = '0;
        for (int k = 0; k < 10 * (div + 1); k++) begin
            sym = k / (div + 1);
            if (sym == 0)      f[k] = 1'b0;
            else if (sym <= 8) f[k] = b[sym-1];
            else               f[k] = 1'b1;
        end
        return f;
    endfunction

    task automatic bus_xfer(input logic rw, input logic [2:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] rdata, output int lat);
        @(negedge sys_clk);
        bus_enable = 1'b1;
        bus_rw = rw;
        bus_address = addr;
        bus_write_data = wdata;
        bus_byte_enable = be;
        lat = 0;
        rdata = 32'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge sys_clk);
            if (bus_acknowledge) begin
                lat = k;
                rdata = bus_read_data;
                break;
            end
        end
        bus_enable = 1'b0;
        if (lat == 0) check_eq("ack_timeout", bus_acknowledge, 1);
        $display("XFER %s addr=%0d wdata=0x%08h be=%b rdata=0x%08h lat=%0d",
                 rw ? "RD" : "WR", addr, wdata, be, rdata, lat);
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] rd;
        int lat;
        bus_xfer(1'b0, addr, wdata, be, rd, lat);
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] rdata);
        int lat;
        bus_xfer(1'b1, addr, 32'd0, 4'd0, rdata, lat);
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        for (int k = 0; k < budget && frames_seen < target; k++) @(negedge sys_clk);
        check_eq(tag, frames_seen, target);
    endtask

    // Frame monitor: captures one full 8N1 frame per falling start edge and scores it.
    logic [63:0] cap;
    int n_samp;
    int start_cyc;
    logic [7:0] exp_byte;
    initial begin
        forever begin
            @(negedge sys_clk);
            if (mon_en && !sys_rst && uart_txd === 1'b0) begin
                start_cyc = cyc;
                b2b_gap = start_cyc - last_end_cyc;
                n_samp = 10 * (cur_div + 1);
                cap = '0;
                for (int k = 0; k < n_samp; k++) begin
                    if (k > 0) @(negedge sys_clk);
                    cap[k] = uart_txd;
                    if (bus_irq) irq_busy_seen = 1'b1;
                end
                last_end_cyc = cyc;
                if (byte_q.size() == 0) begin
                    check_eq("frame_unexpected", byte_q.size(), 1);
                end else begin
                    exp_byte = byte_q.pop_front();
                    check_eq("frame_bits", cap, frame_bits(exp_byte, cur_div));
                    $display("FRAME byte=0x%02h start_cyc=%0d gap=%0d", exp_byte, start_cyc, b2b_gap);
                end
                frames_seen++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rd;
    int lat;
    int irq_cyc;
    int model_level;
    bit model_ovf;
    logic [7:0] ack_pat;
    logic [31:0] t4_data;
    initial begin
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_eq("rst_ack", bus_acknowledge, 0);
        check_eq("rst_txd", uart_txd, 1);
        check_eq("rst_irq", bus_irq, 0);
        check_eq("rst_rdata", bus_read_data, 0);

        // Reset values and latency
        bus_xfer(1'b1, 3'd1, 32'd0, 4'd0, rd, lat);
        check_eq("status_rst", rd, 32'h2);
        check_eq("ack_latency", lat, 1);
        bus_read(3'd3, rd);  check_eq("baud_rst", rd, 433);
        bus_read(3'd2, rd);  check_eq("ctrl_rst", rd, 0);
        bus_read(3'd0, rd);  check_eq("txdata_rd", rd, 0);
        bus_read(3'd6, rd);  check_eq("unmapped_rd", rd, 0);
        bus_write(3'd6, 32'hFFFF_FFFF, 4'hF);
        bus_read(3'd1, rd);  check_eq("status_after_unmapped", rd, 32'h2);

        // Baud divider lanes and zero clamp
        bus_write(3'd3, 32'd0, 4'b0011);
        bus_read(3'd3, rd);  check_eq("baud_zero_clamp", rd, 1);
        bus_write(3'd3, 32'h0000_1234, 4'b0001);
        bus_read(3'd3, rd);  check_eq("baud_lane0", rd, 32'h34);
        bus_write(3'd3, 32'h0000_5600, 4'b0010);
        bus_read(3'd3, rd);  check_eq("baud_lane1", rd, 32'h5634);
        bus_write(3'd3, 32'd3, 4'b0011);
        cur_div = 3;
        bus_read(3'd3, rd);  check_eq("baud_3", rd, 3);

        // Single frame of 0x55
        bus_write(3'd2, 32'h2, 4'b0001);
        byte_q.push_back(8'h55);
        bus_write(3'd0, 32'h55, 4'b0001);
        wait_frames(1, 200, "frame_0x55_done");

        // Fill FIFO with TX disabled, overflow, clear, then drain
        bus_write(3'd2, 32'h0, 4'b0001);
        model_level = 0;
        model_ovf = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (model_level < 16) begin
                byte_q.push_back(8'hA0 + 8'(i));
                model_level++;
            end else begin
                model_ovf = 1'b1;
            end
            bus_write(3'd0, 32'hA0 + 32'(i), 4'b0001);
        end
        bus_read(3'd1, rd);
        check_eq("status_full_ovf", rd, {16'd0, 8'(model_level), 4'd0, model_ovf, 1'b0, 1'b0, 1'b1});
        bus_write(3'd1, 32'h8, 4'b0001);
        bus_read(3'd1, rd);  check_eq("status_ovf_cleared", rd, 32'h1001);
        bus_write(3'd2, 32'h2, 4'b0001);
        wait_frames(17, 16 * 45 + 200, "fifo_drain_done");
        repeat (2) @(negedge sys_clk);
        bus_read(3'd1, rd);  check_eq("status_drained", rd, 32'h2);

        // Enable held across back-to-back reads
        @(negedge sys_clk);
        bus_enable = 1'b1;
        bus_rw = 1'b1;
        bus_address = 3'd1;
        ack_pat = 8'd0;
        t4_data = 32'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            ack_pat[k] = bus_acknowledge;
            if (bus_acknowledge) t4_data = t4_data | bus_read_data;
            if (k == 5) bus_enable = 1'b0;
        end
        $display("XFER held-enable ack_pattern=%b", ack_pat);
        check_eq("held_ack_pattern", ack_pat, 8'b0001_0101);
        check_eq("held_ack_count", $countones(ack_pat), 3);
        check_eq("held_rdata", t4_data, 32'h2);

        // IRQ around two back-to-back frames
        bus_write(3'd2, 32'h3, 4'b0001);
        repeat (3) @(negedge sys_clk);
        check_eq("irq_idle_empty", bus_irq, 1);
        irq_busy_seen = 1'b0;
        byte_q.push_back(8'h3C);
        bus_write(3'd0, 32'h3C, 4'b0001);
        byte_q.push_back(8'hC3);
        bus_write(3'd0, 32'hC3, 4'b0001);
        irq_cyc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge sys_clk);
            if (bus_irq && frames_seen >= 19) begin
                irq_cyc = cyc;
                break;
            end
        end
        check_eq("irq_frames_done", frames_seen, 19);
        check_eq("irq_rise_delay", irq_cyc - last_end_cyc, 2);
        check_eq("irq_low_while_busy", irq_busy_seen, 0);
        check_eq("b2b_no_idle_gap", (b2b_gap >= 1 && b2b_gap <= 2), 1);

        // Reset in the middle of the data bits
        mon_en = 1'b0;
        bus_write(3'd0, 32'h00, 4'b0001);
        bus_write(3'd0, 32'h00, 4'b0001);
        repeat (8) @(negedge sys_clk);
        check_eq("txd_low_in_data", uart_txd, 0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check_eq("rst_mid_txd", uart_txd, 1);
        check_eq("rst_mid_ack", bus_acknowledge, 0);
        bus_read(3'd1, rd);  check_eq("rst_mid_status", rd, 32'h2);
        bus_read(3'd2, rd);  check_eq("rst_mid_ctrl", rd, 0);
        bus_read(3'd3, rd);  check_eq("rst_mid_baud", rd, 433);
        check_eq("rst_mid_txd_idle", uart_txd, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
